// File: rtl/ctrl_smpseq_if.sv
// rtl/ctrl_smpseq_if.sv - control and strobe bundle between sample sequencer and address driver
interface ctrl_smpseq_if #(
    parameter int WIDTH = 3,
    parameter int PHW   = 16
);
    logic             start;
    logic             stop;
    logic             in_valid;
    logic [PHW-1:0]   step;
    logic             en_init;
    logic             en_load;
    logic             new_smp;
    logic             out_smp;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] error_reg;
    logic             busy;
    logic             ovf;

    modport master (
        output start, stop, in_valid, step,
        input  en_init, en_load, new_smp, out_smp, result_reg, error_reg, busy, ovf
    );

    modport slave (
        input  start, stop, in_valid, step,
        output en_init, en_load, new_smp, out_smp, result_reg, error_reg, busy, ovf
    );
endinterface

// File: rtl/ctrl_smpseq.sv
// rtl/ctrl_smpseq.sv - ring-init and load sequencer with fractional phase accumulator
module ctrl_smpseq #(
    parameter int WIDTH = 3,
    parameter int PHW   = 16
) (
    input  logic         clk,
    input  logic         rst,
    ctrl_smpseq_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] wptr_q, wptr_d;
    logic [PHW-1:0]   acc_q, acc_d;
    logic             ovf_d;
    logic             en_init_d;
    logic             en_load_d;
    logic             new_smp_d;
    logic             out_smp_d;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] error_d;
    logic             busy_d;
    logic [PHW:0]     acc_sum;

    // Phase accumulation one bit wider than the accumulator; the top bit is the output-sample carry.
    assign acc_sum = {1'b0, acc_q} + {1'b0, bus.step};

    // Next state plus next value of every registered output. Outputs are computed for the
    // cycle being entered, so the consumer sees the strobe aligned with the state it belongs to.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wptr_d    = wptr_q;
        acc_d     = acc_q;
        ovf_d     = bus.ovf;
        en_init_d = 1'b0;
        en_load_d = 1'b0;
        new_smp_d = 1'b0;
        out_smp_d = 1'b0;
        result_d  = bus.result_reg;
        error_d   = bus.error_reg;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_INIT;
                    cnt_d     = '0;
                    wptr_d    = '0;
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                    // first init slot (0): consumer writes slot 0 when result points one ahead
                    en_init_d = 1'b1;
                    new_smp_d = 1'b1;
                    result_d  = WIDTH'(1);
                    error_d   = '0;
                end
            end
            S_INIT: begin
                if (bus.in_valid) begin
                    ovf_d = 1'b1;
                end
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '1) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d     = cnt_q + WIDTH'(1);
                    en_init_d = 1'b1;
                    result_d  = cnt_q + WIDTH'(2);
                    error_d   = cnt_q + WIDTH'(1);
                end
            end
            S_RUN: begin
                // a sample arriving with stop is still loaded before the sequencer goes idle
                if (bus.in_valid) begin
                    en_load_d = 1'b1;
                    result_d  = wptr_q;
                    error_d   = wptr_q - WIDTH'(1);
                    acc_d     = acc_sum[PHW-1:0];
                    out_smp_d = acc_sum[PHW];
                    wptr_d    = wptr_q + WIDTH'(1);
                end
                if (bus.stop) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            wptr_q         <= '0;
            acc_q          <= '0;
            bus.ovf        <= 1'b0;
            bus.en_init    <= 1'b0;
            bus.en_load    <= 1'b0;
            bus.new_smp    <= 1'b0;
            bus.out_smp    <= 1'b0;
            bus.result_reg <= '0;
            bus.error_reg  <= '0;
            bus.busy       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wptr_q         <= wptr_d;
            acc_q          <= acc_d;
            bus.ovf        <= ovf_d;
            bus.en_init    <= en_init_d;
            bus.en_load    <= en_load_d;
            bus.new_smp    <= new_smp_d;
            bus.out_smp    <= out_smp_d;
            bus.result_reg <= result_d;
            bus.error_reg  <= error_d;
            bus.busy       <= busy_d;
        end
    end
endmodule

// File: doc/ctrl_smpseq.md
Name: ctrl_smpseq

Overview:
Sample sequencer for the SRC controller, directly upstream of the register-file address driver. It produces the `en_init`, `en_load`, `new_smp` and `out_smp` strobes and the `result_reg`/`error_reg` addresses that the driver latches on the falling clock edge. It runs a ring-buffer fill sequence after start, then a write pointer and a fractional phase accumulator. Together these decide, per input sample, which slot is loaded and whether an output sample is due.

Parameters:
- WIDTH, 3, register-file address width; ring depth NREG = 2**WIDTH.
- PHW, 16, phase accumulator width; the conversion ratio is step/2**PHW.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin ring init; accepted in IDLE only.
- stop  in  1  return to IDLE after the current cycle.
- in_valid  in  1  new input sample strobe, one cycle.
- step  in  PHW  phase increment, sampled on each accepted in_valid.
- en_init  out  1  ring init cycle.
- en_load  out  1  sample load cycle.
- new_smp  out  1  first init cycle (slot 0).
- out_smp  out  1  output sample due.
- result_reg  out  WIDTH  result slot address.
- error_reg  out  WIDTH  error slot address.
- busy  out  1  high in INIT or RUN.
- ovf  out  1  sticky: in_valid arrived during INIT.

Behaviour:
- All outputs are registered on posedge, so they are stable at the consumer's negedge sample.
- rst low sets, immediately: state=IDLE, cnt=0, wptr=0, acc=0, ovf=0, and every output 0. This holds regardless of state, including mid-INIT or mid-RUN.
- States: IDLE, INIT, RUN.
- IDLE:
  - All strobes are 0.
  - start=1 -> INIT with cnt=0, wptr=0, acc=0, ovf=0.
  - stop and in_valid are ignored.
- INIT: one cycle per slot, cnt = 0..NREG-1. Each cycle:
  - en_init=1.
  - new_smp=(cnt==0).
  - result_reg=(cnt+1) mod NREG, so the consumer writes slot cnt.
  - error_reg=cnt.
  - At cnt==NREG-1 -> RUN next cycle, so INIT lasts exactly NREG cycles.
  - in_valid during INIT is dropped and sets ovf.
  - stop during INIT -> IDLE next cycle; no further en_init.
- RUN: in_valid=1 in cycle N gives a single-cycle en_load=1 in cycle N+1, with:
  - result_reg=wptr.
  - error_reg=(wptr-1) mod NREG.
  - {carry,acc_next} = acc + step, computed PHW+1 bits wide; acc <= acc_next (wraps mod 2**PHW).
  - out_smp=carry, in the same cycle as en_load.
  - wptr <= wptr+1 mod NREG (wraps NREG-1 -> 0).
- RUN, back-to-back in_valid: every cycle produces an en_load every cycle; no sample is lost.
- RUN, idle cycles: with no in_valid, en_load=0 and out_smp=0, while result_reg and error_reg hold their last values.
- step=0: out_smp never asserts.
- step=2**PHW-1: carry on every load except the first.
- stop in RUN -> IDLE next cycle. A simultaneous in_valid is still processed: its en_load appears in the cycle IDLE is entered, then everything goes idle.
- start outside IDLE is ignored.
- ovf clears only on rst or an accepted start.
- busy = (state != IDLE), registered.
- en_init and en_load are never high together.

Test Plan:
1. rst low, then high; start pulse (WIDTH=3) -> 8 cycles en_init=1.
   - new_smp=1 only on the first cycle.
   - result_reg sequence 1,2,...,7,0; error_reg 0..7.
   - Then busy=1 with en_load=0.
2. RUN with step=0x8000 and 4 spaced in_valid pulses -> 4 en_load pulses, each one cycle after its in_valid.
   - result_reg 0,1,2,3; error_reg 7,0,1,2.
   - out_smp pattern 0,1,0,1.
3. 10 back-to-back in_valid with step=0x4000 -> 10 consecutive en_load cycles.
   - wptr wraps 7->0.
   - out_smp high on loads 4 and 8 only.
4. in_valid pulsed during INIT cycle 3 -> ovf=1 and stays 1 through RUN; INIT length is unchanged at 8. A new start after stop clears ovf.
5. stop and in_valid in the same RUN cycle -> one final en_load, then IDLE with busy=0. A later in_valid produces no en_load.
6. rst asserted mid-RUN (wptr=5, acc nonzero) -> all outputs 0 at once. After start, the first RUN load uses result_reg=0 and starts from acc=0.
